// File: rtl/creek_trace_reader.sv
// Creek core trace capture: dedups (state, pc, instr) tuples into a FIFO
// that the HPS drains over an Avalon-MM slave with read latency 1.
module creek_trace_reader #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [9:0]  pc,
  input  logic [4:0]  state,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  logic [4:0]            smp_state;
  logic [9:0]            smp_pc;
  logic [15:0]           smp_instr;
  logic                  smp_armed;
  logic [30:0]           prev_tuple;
  logic                  prev_valid;
  logic                  armed;
  logic                  overflow;
  logic [15:0]           drops;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           mem [DEPTH];

  logic [30:0] tuple;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_ctrl;
  logic        clr;
  logic        arm_rise;
  logic        capture;
  logic        push;
  logic        drop;
  logic        unused_wdata;

  assign tuple    = {smp_state, smp_pc, smp_instr};
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = avs_read && (avs_address == 2'd1) && !empty;
  assign wr_ctrl  = avs_write && (avs_address == 2'd0);
  assign clr      = wr_ctrl && avs_writedata[1];
  assign arm_rise = wr_ctrl && avs_writedata[0] && !armed;
  // smp_armed gates out the sample taken on the same edge as the arm write
  assign capture  = armed && smp_armed &&
                    (!prev_valid || (tuple != prev_tuple));
  assign push     = capture && (!full || pop);
  assign drop     = capture && full && !pop;
  assign unused_wdata = ^avs_writedata[31:2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp_state  <= '0;
      smp_pc     <= '0;
      smp_instr  <= '0;
      smp_armed  <= 1'b0;
      prev_tuple <= '0;
      prev_valid <= 1'b0;
      armed      <= 1'b0;
      overflow   <= 1'b0;
      drops      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      smp_state <= state;
      smp_pc    <= pc;
      smp_instr <= instr;
      smp_armed <= armed;
      if (wr_ctrl)
        armed <= avs_writedata[0];
      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        drops      <= '0;
        prev_valid <= 1'b0;
      end else begin
        if (arm_rise)
          prev_valid <= 1'b0;
        else if (capture) begin
          prev_tuple <= tuple;
          prev_valid <= 1'b1;
        end
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (drop) begin
          overflow <= 1'b1;
          if (drops != 16'hFFFF)
            drops <= drops + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push && !clr)
      mem[wr_ptr] <= {1'b1, tuple};
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      avs_readdata <= '0;
    else if (avs_read) begin
      case (avs_address)
        2'd0: avs_readdata <= {{(16-CW){1'b0}}, count,
                               13'd0, overflow, armed, empty};
        2'd1: avs_readdata <= empty ? 32'd0 : mem[rd_ptr];
        2'd2: avs_readdata <= {16'd0, drops};
        2'd3: avs_readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_creek_trace_reader.sv
// Bench for creek_trace_reader: directed literal checks plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_creek_trace_reader;

  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic [9:0]  pc = '0;
  logic [4:0]  state = '0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  always #5 clk = ~clk;

  creek_trace_reader #(.DEPTH_LOG2(DL)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instr(instr),
    .pc(pc),
    .state(state),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata)
  );

  int n_total = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
  endtask

  // Reference model: a queue of entries plus the dedup/arm bookkeeping.
  logic [31:0] q[$];
  logic [30:0] m_smp = '0;
  bit          m_elig = 1'b0;
  logic [30:0] m_prev = '0;
  bit          m_pv = 1'b0;
  bit          m_armed = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  logic [31:0] m_rd = '0;

  task automatic model_step();
    bit cap, pop, wr0, clr;
    if (!reset_n) begin
      q.delete();
      m_smp = '0; m_elig = 1'b0; m_prev = '0; m_pv = 1'b0;
      m_armed = 1'b0; m_ovf = 1'b0; m_drops = 0; m_rd = '0;
      return;
    end
    if (avs_read) begin
      case (avs_address)
        2'd0: m_rd = {16'(q.size()), 13'd0, m_ovf, m_armed, q.size() == 0};
        2'd1: m_rd = (q.size() > 0) ? q[0] : 32'd0;
        2'd2: m_rd = {16'd0, 16'(m_drops)};
        default: m_rd = 32'd0;
      endcase
    end
    pop = avs_read && (avs_address == 2'd1) && (q.size() > 0);
    cap = m_armed && m_elig && (!m_pv || (m_smp != m_prev));
    wr0 = avs_write && (avs_address == 2'd0);
    clr = wr0 && avs_writedata[1];
    if (clr) begin
      q.delete();
      m_ovf = 1'b0; m_drops = 0; m_pv = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back({1'b1, m_smp});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        m_prev = m_smp;
        m_pv = 1'b1;
      end
    end
    m_elig = m_armed;
    if (wr0) begin
      if (avs_writedata[0] && !m_armed) m_pv = 1'b0;
      m_armed = avs_writedata[0];
    end
    m_smp = {state, pc, instr};
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk)
    if (chk_en) check("rdata_model", avs_readdata, m_rd);

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string nm);
    avs_read = 1'b1;
    avs_address = a;
    @(negedge clk);
    avs_read = 1'b0;
    check(nm, avs_readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1;
    avs_address = a;
    avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic tup(input logic [4:0] s, input logic [9:0] p,
                     input logic [15:0] i);
    state = s;
    pc = p;
    instr = i;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    cyc(2);
    check("reset_rdata", avs_readdata, 32'h0);
    chk_en = 1'b1;
    reset_n = 1'b1;
    rd(2'd0, 32'h0000_0001, "reset_status");
    rd(2'd1, 32'h0000_0000, "reset_data");
    rd(2'd2, 32'h0000_0000, "reset_drops");
    rd(2'd3, 32'h0000_0000, "addr3");

    // dedup of a held tuple
    tup(5'd3, 10'h010, 16'hABCD);
    wr(2'd0, 32'h1);
    cyc(5);
    tup(5'd3, 10'h011, 16'hABCD);
    cyc(3);
    rd(2'd0, 32'h0002_0002, "dedup_status");
    rd(2'd1, 32'h8C10_ABCD, "dedup_data0");
    rd(2'd1, 32'h8C11_ABCD, "dedup_data1");
    rd(2'd1, 32'h0000_0000, "dedup_empty");

    // overflow with 7 distinct tuples into 4 slots
    for (int i = 0; i < 7; i++) begin
      tup(5'd3, 10'(10'h100 + i), 16'hABCD);
      @(negedge clk);
    end
    cyc(3);
    rd(2'd0, 32'h0004_0006, "ovf_status");
    rd(2'd2, 32'h0000_0003, "ovf_drops");

    // pop and push on the same edge while full
    tup(5'd3, 10'h1F0, 16'hABCD);
    @(negedge clk);
    rd(2'd1, 32'h8D00_ABCD, "fullpop_data0");
    rd(2'd0, 32'h0004_0006, "fullpop_status");
    rd(2'd2, 32'h0000_0003, "fullpop_drops");
    rd(2'd1, 32'h8D01_ABCD, "fullpop_data1");
    rd(2'd1, 32'h8D02_ABCD, "fullpop_data2");
    rd(2'd1, 32'h8D03_ABCD, "fullpop_data3");
    rd(2'd1, 32'h8DF0_ABCD, "fullpop_new_last");
    rd(2'd1, 32'h0000_0000, "fullpop_empty");

    // clear while entries pending and a push in flight
    tup(5'd3, 10'h020, 16'hABCD);
    @(negedge clk);
    tup(5'd3, 10'h021, 16'hABCD);
    @(negedge clk);
    tup(5'd3, 10'h022, 16'hABCD);
    @(negedge clk);
    wr(2'd0, 32'h3);
    rd(2'd0, 32'h0000_0003, "clr_status");
    rd(2'd2, 32'h0000_0000, "clr_drops");
    rd(2'd0, 32'h0001_0002, "clr_recapture");
    rd(2'd1, 32'h8C22_ABCD, "clr_first_entry");

    // reset mid-trace
    tup(5'd3, 10'h030, 16'hABCD);
    @(negedge clk);
    tup(5'd3, 10'h031, 16'hABCD);
    @(negedge clk);
    tup(5'd3, 10'h032, 16'hABCD);
    cyc(3);
    rd(2'd0, 32'h0003_0002, "prerst_status");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'h0000_0001, "rst_status");
    tup(5'd5, 10'h3FF, 16'h1234);
    cyc(4);
    rd(2'd0, 32'h0000_0001, "rst_nocapture");
    rd(2'd1, 32'h0000_0000, "rst_data");
    rd(2'd2, 32'h0000_0000, "rst_drops");
    wr(2'd0, 32'h1);
    cyc(3);
    rd(2'd0, 32'h0001_0002, "rearm_status");
    rd(2'd1, 32'h97FF_1234, "rearm_data");

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 1) == 1)
        tup(5'($urandom_range(0, 1)), 10'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 16'h5A5A : 16'hA5A5);
      r = int'($urandom_range(0, 99));
      avs_read = (r < 50);
      avs_write = (r >= 42) && (r < 56);
      if (r < 30) avs_address = 2'd1;
      else if (avs_write && $urandom_range(0, 3) != 0) avs_address = 2'd0;
      else avs_address = 2'($urandom_range(0, 3));
      avs_writedata = $urandom;
      avs_writedata[1] = ($urandom_range(0, 9) == 0);
      avs_writedata[0] = ($urandom_range(0, 6) != 0);
      @(negedge clk);
    end
    avs_read = 1'b0;
    avs_write = 1'b0;
    reset_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
